// File: rtl/ber_pkg.sv
// Shared constants and helpers for the bit-error-rate meter.
package ber_pkg;

    localparam int MODE_CYCLE = 0;
    localparam int MODE_BIT   = 1;

    // Returns {saturated, sum}. The sum is clamped to 2^w-1.
    function automatic logic [64:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        if (sum > lim) return {1'b1, lim[63:0]};
        return {1'b0, sum[63:0]};
    endfunction

    function automatic int unsigned clamp_nb(input int unsigned n, input int unsigned dw);
        return (n > dw) ? dw : n;
    endfunction

endpackage

// File: rtl/ber_popcount.sv
// Combinational population count of the masked difference word.
module ber_popcount #(
    parameter int DATA_W = 8,
    parameter int PC_W   = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [PC_W-1:0]   o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < DATA_W; i++)
            o_count = o_count + PC_W'(i_data[i]);
    end

endmodule

// File: rtl/ber_meter.sv
// Bit-error-rate meter: per-window error/bit accumulation with a result strobe.
// Optional peak-error hold is enabled by defining BER_PEAK_HOLD_EN.
module ber_meter
    import ber_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int CNT_W         = 32,
    parameter int MODE          = 0,
    parameter int WINDOW_CYCLES = 240_000_000,
    parameter int WINDOW_BITS   = 1_000_000,
    parameter int NB_W          = $clog2(DATA_W + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] sent_data,
    input  logic [DATA_W-1:0] recv_data,
    input  logic [NB_W-1:0]   number_of_bits,
    output logic              valid_o,
    output logic [CNT_W-1:0]  error_count,
    output logic [CNT_W-1:0]  bit_count,
    output logic              overflow_o,
    output logic [CNT_W-1:0]  peak_errors
);

    localparam int CYC_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    logic [NB_W-1:0]   w_n;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] r_diff;
    logic [NB_W-1:0]   r_nb;
    logic              r_v;
    logic [NB_W-1:0]   w_pop;
    logic [63:0]       w_add_err, w_add_bit;
    logic [64:0]       w_err_res, w_bit_res;
    logic [CNT_W-1:0]  w_err_sum, w_bit_sum;
    logic              w_ovf, w_close;
    logic [CNT_W-1:0]  r_err_acc, r_bit_acc;
    logic              r_ovf;
    logic [CYC_W-1:0]  r_cyc;

    always_comb begin
        w_n    = NB_W'(clamp_nb(32'(number_of_bits), DATA_W));
        w_mask = '0;
        for (int i = 0; i < DATA_W; i++)
            w_mask[i] = (i < int'(w_n));
    end

    always_ff @(posedge CLK) begin
        if (!RST || clear_i) begin
            r_diff <= '0;
            r_nb   <= '0;
            r_v    <= 1'b0;
        end else begin
            r_diff <= (sent_data ^ recv_data) & w_mask;
            r_nb   <= w_n;
            r_v    <= valid_i;
        end
    end

    ber_popcount #(.DATA_W(DATA_W), .PC_W(NB_W)) u_pop (
        .i_data  (r_diff),
        .o_count (w_pop)
    );

    // Stage-2 sums double as the close-cycle snapshot.
    always_comb begin
        w_add_err = r_v ? 64'(w_pop) : 64'd0;
        w_add_bit = r_v ? 64'(r_nb)  : 64'd0;
        w_err_res = sat_add(64'(r_err_acc), w_add_err, CNT_W);
        w_bit_res = sat_add(64'(r_bit_acc), w_add_bit, CNT_W);
        w_err_sum = CNT_W'(w_err_res[63:0]);
        w_bit_sum = CNT_W'(w_bit_res[63:0]);
        w_ovf     = r_ovf | w_err_res[64] | w_bit_res[64];
        if (MODE == MODE_CYCLE)
            w_close = (r_cyc == CYC_W'(WINDOW_CYCLES - 1));
        else
            w_close = (w_bit_res[63:0] >= 64'(WINDOW_BITS));
    end

    always_ff @(posedge CLK) begin
        if (!RST || clear_i)
            r_cyc <= '0;
        else if (MODE == MODE_CYCLE)
            r_cyc <= w_close ? '0 : r_cyc + CYC_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RST || clear_i || w_close) begin
            r_err_acc <= '0;
            r_bit_acc <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_err_acc <= w_err_sum;
            r_bit_acc <= w_bit_sum;
            r_ovf     <= w_ovf;
        end
    end

    // clear_i suppresses the strobe but leaves the last published result intact.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            valid_o     <= 1'b0;
            error_count <= '0;
            bit_count   <= '0;
            overflow_o  <= 1'b0;
        end else if (clear_i) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= w_close;
            if (w_close) begin
                error_count <= w_err_sum;
                bit_count   <= w_bit_sum;
                overflow_o  <= w_ovf;
            end
        end
    end

`ifdef BER_PEAK_HOLD_EN
    logic [CNT_W-1:0] r_peak;

    always_ff @(posedge CLK) begin
        if (!RST || clear_i)
            r_peak <= '0;
        else if (w_close && (w_err_sum > r_peak))
            r_peak <= w_err_sum;
    end

    assign peak_errors = r_peak;
`else
    assign peak_errors = '0;
`endif

endmodule

// File: tb/tb_ber_meter.sv
// Directed bench for ber_meter: cycle window, bit window, saturation, clear, peak, reset.
module tb_ber_meter;

`ifdef BER_PEAK_HOLD_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic       CLK, RST, clr, vin;
    logic [7:0] sd, rd;
    logic [3:0] nb;

    logic        v0, o0, v1, o1, v2, o2;
    logic [31:0] e0, b0, p0, e1, b1, p1;
    logic [3:0]  e2, b2, p2;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    ber_meter #(.DATA_W(8), .CNT_W(32), .MODE(0), .WINDOW_CYCLES(16), .WINDOW_BITS(32)) u0 (
        .CLK(CLK), .RST(RST), .clear_i(clr), .valid_i(vin), .sent_data(sd), .recv_data(rd),
        .number_of_bits(nb), .valid_o(v0), .error_count(e0), .bit_count(b0),
        .overflow_o(o0), .peak_errors(p0));

    ber_meter #(.DATA_W(8), .CNT_W(32), .MODE(1), .WINDOW_CYCLES(16), .WINDOW_BITS(32)) u1 (
        .CLK(CLK), .RST(RST), .clear_i(clr), .valid_i(vin), .sent_data(sd), .recv_data(rd),
        .number_of_bits(nb), .valid_o(v1), .error_count(e1), .bit_count(b1),
        .overflow_o(o1), .peak_errors(p1));

    ber_meter #(.DATA_W(8), .CNT_W(4), .MODE(0), .WINDOW_CYCLES(16), .WINDOW_BITS(32)) u2 (
        .CLK(CLK), .RST(RST), .clear_i(clr), .valid_i(vin), .sent_data(sd), .recv_data(rd),
        .number_of_bits(nb), .valid_o(v2), .error_count(e2), .bit_count(b2),
        .overflow_o(o2), .peak_errors(p2));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // Leaves the bench at the start of cycle 0 (first cycle with RST high).
    task automatic do_reset();
        RST = 1'b0; clr = 1'b0; vin = 1'b0; sd = '0; rd = '0; nb = '0;
        tick();
        tick();
        RST = 1'b1;
        cyc = 0;
    endtask

    task automatic sample(input logic [7:0] s, input logic [7:0] r, input logic [3:0] n);
        sd = s; rd = r; nb = n; vin = 1'b1;
        tick();
        vin = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; clr = 1'b0; vin = 1'b1; sd = 8'hFF; rd = 8'h00; nb = 4'd8;
        tick();
        tick();
        vin = 1'b0;
        checks++; if ({v0, e0, b0, o0, p0} !== '0) begin fails++; $display("FAIL reset_u0 got=%0d/%0d/%0d/%0d/%0d exp=0", v0, e0, b0, o0, p0); end
        checks++; if ({v1, e1, b1, o1, p1} !== '0) begin fails++; $display("FAIL reset_u1 got=%0d/%0d/%0d/%0d exp=0", v1, e1, b1, o1); end
        checks++; if ({v2, e2, b2, o2, p2} !== '0) begin fails++; $display("FAIL reset_u2 got=%0d/%0d/%0d/%0d exp=0", v2, e2, b2, o2); end
    endtask

    task automatic test_single();
        do_reset();
        run_to(3);
        sample(8'hFF, 8'h0F, 4'd8);
        run_to(15);
        checks++; if (v0 !== 1'b0) begin fails++; $display("FAIL single_early_strobe got=%0b exp=0", v0); end
        tick();
        checks++; if (v0 !== 1'b1) begin fails++; $display("FAIL single_strobe got=%0b exp=1", v0); end
        checks++; if (e0 !== 32'd4) begin fails++; $display("FAIL single_err got=%0d exp=4", e0); end
        checks++; if (b0 !== 32'd8) begin fails++; $display("FAIL single_bits got=%0d exp=8", b0); end
        checks++; if (o0 !== 1'b0) begin fails++; $display("FAIL single_ovf got=%0b exp=0", o0); end
        tick();
        checks++; if (v0 !== 1'b0 || e0 !== 32'd4) begin fails++; $display("FAIL single_hold got v=%0b err=%0d exp v=0 err=4", v0, e0); end
    endtask

    task automatic test_nbits();
        do_reset();
        run_to(3);
        sample(8'hF0, 8'h00, 4'd4);
        run_to(16);
        checks++; if (v0 !== 1'b1 || e0 !== 32'd0 || b0 !== 32'd4) begin fails++; $display("FAIL nbits4 got v=%0b err=%0d bits=%0d exp 1/0/4", v0, e0, b0); end
        run_to(20);
        sample(8'hFF, 8'h00, 4'd12);
        run_to(32);
        checks++; if (v0 !== 1'b1 || e0 !== 32'd8 || b0 !== 32'd8) begin fails++; $display("FAIL nbits_clamp got v=%0b err=%0d bits=%0d exp 1/8/8", v0, e0, b0); end
    endtask

    task automatic test_bit_window();
        do_reset();
        nb = 4'd8;
        vin = 1'b1;
        while (cyc <= 10) begin
            sd = 8'(cyc * 37);
            rd = 8'(cyc * 37) ^ 8'h01;
            #0;
            checks++; if (v1 !== (cyc == 5 || cyc == 9)) begin fails++; $display("FAIL bitwin_strobe cyc=%0d got=%0b exp=%0b", cyc, v1, (cyc == 5 || cyc == 9)); end
            if (cyc == 5 || cyc == 9) begin
                checks++; if (e1 !== 32'd4 || b1 !== 32'd32) begin fails++; $display("FAIL bitwin_counts cyc=%0d got err=%0d bits=%0d exp 4/32", cyc, e1, b1); end
            end
            tick();
        end
        vin = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        run_to(3);
        sd = 8'hFF; rd = 8'h00; nb = 4'd8; vin = 1'b1;
        tick();
        tick();
        vin = 1'b0;
        run_to(16);
        checks++; if (v2 !== 1'b1 || e2 !== 4'd15 || b2 !== 4'd15) begin fails++; $display("FAIL sat_counts got v=%0b err=%0d bits=%0d exp 1/15/15", v2, e2, b2); end
        checks++; if (o2 !== 1'b1) begin fails++; $display("FAIL sat_ovf got=%0b exp=1", o2); end
        checks++; if (e0 !== 32'd16 || b0 !== 32'd16 || o0 !== 1'b0) begin fails++; $display("FAIL wide_nosat got err=%0d bits=%0d ovf=%0b exp 16/16/0", e0, b0, o0); end
        run_to(32);
        checks++; if (v2 !== 1'b1 || o2 !== 1'b0 || e2 !== 4'd0 || b2 !== 4'd0) begin fails++; $display("FAIL sat_clean got v=%0b ovf=%0b err=%0d bits=%0d exp 1/0/0/0", v2, o2, e2, b2); end
    endtask

    task automatic test_clear();
        do_reset();
        run_to(3);
        sample(8'hFF, 8'h0F, 4'd8);
        run_to(16);
        checks++; if (v0 !== 1'b1 || e0 !== 32'd4) begin fails++; $display("FAIL clr_pre got v=%0b err=%0d exp 1/4", v0, e0); end
        run_to(20);
        sample(8'hFF, 8'h00, 4'd8);
        run_to(26);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (v0 !== 1'b0 || e0 !== 32'd4) begin fails++; $display("FAIL clr_nostrobe got v=%0b err=%0d exp 0/4", v0, e0); end
        run_to(30);
        sample(8'h03, 8'h00, 4'd8);
        run_to(32);
        checks++; if (v0 !== 1'b0 || e0 !== 32'd4 || b0 !== 32'd8) begin fails++; $display("FAIL clr_oldbound got v=%0b err=%0d bits=%0d exp 0/4/8", v0, e0, b0); end
        run_to(42);
        checks++; if (v0 !== 1'b0 || e0 !== 32'd4) begin fails++; $display("FAIL clr_hold got v=%0b err=%0d exp 0/4", v0, e0); end
        tick();
        checks++; if (v0 !== 1'b1 || e0 !== 32'd2 || b0 !== 32'd8) begin fails++; $display("FAIL clr_next got v=%0b err=%0d bits=%0d exp 1/2/8", v0, e0, b0); end
        checks++; if (p0 !== (PEAK_EN ? 32'd2 : 32'd0)) begin fails++; $display("FAIL clr_peak got=%0d exp=%0d", p0, PEAK_EN ? 2 : 0); end
    endtask

    task automatic test_peak_and_midreset();
        do_reset();
        run_to(3);
        sample(8'h1F, 8'h00, 4'd8);
        run_to(16);
        checks++; if (e0 !== 32'd5 || p0 !== (PEAK_EN ? 32'd5 : 32'd0)) begin fails++; $display("FAIL peak_w1 got err=%0d peak=%0d exp 5/%0d", e0, p0, PEAK_EN ? 5 : 0); end
        run_to(20);
        sample(8'h03, 8'h00, 4'd8);
        run_to(32);
        checks++; if (e0 !== 32'd2 || p0 !== (PEAK_EN ? 32'd5 : 32'd0)) begin fails++; $display("FAIL peak_w2 got err=%0d peak=%0d exp 2/%0d", e0, p0, PEAK_EN ? 5 : 0); end
        run_to(36);
        sample(8'h7F, 8'h00, 4'd8);
        run_to(48);
        checks++; if (v0 !== 1'b1 || e0 !== 32'd7 || p0 !== (PEAK_EN ? 32'd7 : 32'd0)) begin fails++; $display("FAIL peak_w3 got v=%0b err=%0d peak=%0d exp 1/7/%0d", v0, e0, p0, PEAK_EN ? 7 : 0); end
        run_to(50);
        sample(8'hFF, 8'h00, 4'd8);
        run_to(53);
        RST = 1'b0;
        sd = 8'hFF; rd = 8'h00; nb = 4'd8; vin = 1'b1;
        tick();
        vin = 1'b0;
        checks++; if ({v0, e0, b0, o0, p0} !== '0) begin fails++; $display("FAIL midreset got v=%0b err=%0d bits=%0d ovf=%0b peak=%0d exp all 0", v0, e0, b0, o0, p0); end
        RST = 1'b1;
        cyc = 0;
        run_to(15);
        checks++; if (v0 !== 1'b0) begin fails++; $display("FAIL midreset_early got=%0b exp=0", v0); end
        tick();
        checks++; if (v0 !== 1'b1 || e0 !== 32'd0 || b0 !== 32'd0) begin fails++; $display("FAIL midreset_discard got v=%0b err=%0d bits=%0d exp 1/0/0", v0, e0, b0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_nbits();
        test_bit_window();
        test_saturate();
        test_clear();
        test_peak_and_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/ber_meter.md
# ber_meter

Parametrised bit-error-rate meter for the receive chain. Each valid cycle it compares a transmitted word with the received word over a selectable number of low-order bits. It accumulates error bits and compared bits over a measurement window, defined either by elapsed cycles or by compared bits. At every window close it publishes a result snapshot with a one-cycle strobe for the display/host logic.

## Interface
- DATA_W, 8, width of compared words
- CNT_W, 32, width of error/bit accumulators and result outputs
- MODE, 0, window mode: 0 = cycle window, 1 = bit window
- WINDOW_CYCLES, 240_000_000, window length in cycles (MODE 0); ≥ 2
- WINDOW_BITS, 1_000_000, compared bits per window (MODE 1); ≥ 1
- NB_W, $clog2(DATA_W+1), width of number_of_bits
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-low reset
- clear_i  in  1  synchronous flush/restart of measurement
- valid_i  in  1  sample qualifier
- sent_data  in  DATA_W  transmitted word
- recv_data  in  DATA_W  received word
- number_of_bits  in  NB_W  count of LSBs compared; values > DATA_W clamp to DATA_W, 0 compares nothing
- valid_o  out  1  one-cycle result strobe
- error_count  out  CNT_W  error bits in last closed window
- bit_count  out  CNT_W  compared bits in last closed window
- overflow_o  out  1  an accumulator saturated in last closed window
- peak_errors  out  CNT_W  maximum error_count since reset/clear (see Configuration)

## Operation
- Stage 1 (registered): mask = low n bits set, n = clamped number_of_bits; diff = (sent_data ^ recv_data) & mask; nb = n; v = valid_i.
- Stage 2: if v, err_acc += popcount(diff), bit_acc += nb. Both saturate at 2^CNT_W−1; saturation sets sticky ovf for the window.
- Window close, MODE 0: cycle counter runs 0..WINDOW_CYCLES−1; close in the cycle where it equals WINDOW_CYCLES−1, then wraps to 0.
- Window close, MODE 1: close in the cycle where bit_acc + current nb ≥ WINDOW_BITS. The crossing sample is included; the excess is not carried forward. The cycle counter is unused.
- At close: snapshot = accumulators plus the same-cycle stage-2 contribution, saturated. Accumulators and ovf reload to 0.
- clear_i: zeroes pipeline, accumulators, cycle counter, ovf and peak. The result outputs keep their values. No valid_o is generated. clear_i wins over a coincident close.
- Reset: all outputs 0, all state 0.

## Timing
- Sample presented in cycle k accumulates at the edge ending cycle k+1 and belongs to the window containing cycle k+1.
- Result outputs update at the edge ending the close cycle. valid_o is high for exactly the following cycle.
- MODE 0: first valid_o in cycle WINDOW_CYCLES, where cycle 0 is the first cycle with RST high. After that, valid_o repeats every WINDOW_CYCLES cycles.
- error_count, bit_count and overflow_o hold steady between strobes.
- RST low mid-window discards the partial window. A sample presented in the reset cycle is dropped.

## Configuration
- BER_PEAK_HOLD_EN defined: peak_errors updates at each close to max(peak, new error_count), visible in the same cycle as valid_o. It is zeroed by RST or clear_i.
- BER_PEAK_HOLD_EN undefined: peak register omitted and peak_errors tied to 0.

## Structure
- Package ber_pkg: MODE_CYCLE/MODE_BIT constants, a saturating-add function, and the clamp-to-DATA_W helper.
- Sub-module ber_popcount (parameter DATA_W, combinational popcount of stage-1 diff), instantiated once.

## Test plan
- DATA_W 8, MODE 0, WINDOW_CYCLES 16: single sample sent 0xFF, recv 0x0F, nbits 8 in cycle 3 → valid_o cycle 16, error_count 4, bit_count 8, overflow_o 0.
- Same config: sent 0xF0, recv 0x00, nbits 4 → error_count 0, bit_count 4. Then nbits 12 with sent 0xFF, recv 0x00 → next window error_count 8, bit_count 8.
- MODE 1, WINDOW_BITS 32: continuous valid, nbits 8, recv = sent^0x01 → valid_o two cycles after the 4th sample, error_count 4, bit_count 32; windows repeat every 4 samples.
- CNT_W 4, MODE 0: two samples, nbits 8, all bits wrong → error_count 15, bit_count 15, overflow_o 1. Next clean window → overflow_o 0.
- clear_i asserted at cycle 10 with partial counts → no strobe at cycle 16; next valid_o at cycle 27. Outputs unchanged until then.
- BER_PEAK_HOLD_EN: windows with errors 5, 2, 7 → peak_errors 5, 5, 7. RST low mid-window → all outputs 0 next cycle.
